// File: rtl/card_table_ctrl.sv
// card_table_ctrl: sole writer of the card-sprite tile RAM. Grants player and
// dealer deal requests (round robin when both are pending), places each card
// at the next slot of its hand row, and sweeps all 256 tiles to empty on a
// table-clear request. Every output is a flop.
module card_table_ctrl #(
  parameter int MAX_CARDS = 8,
  parameter int X_START   = 2,
  parameter int X_STEP    = 2,
  parameter int P_ROW     = 5,
  parameter int D_ROW     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_req,
  input  logic       p_req,
  input  logic [3:0] p_code,
  output logic       p_ack,
  input  logic       d_req,
  input  logic [3:0] d_code,
  output logic       d_ack,
  output logic       err,
  output logic [3:0] p_count,
  output logic [3:0] d_count,
  output logic       busy,
  output logic [4:0] xt,
  output logic [2:0] yt,
  output logic [5:0] ch_out,
  output logic       we_ch
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
  typedef enum logic {PLAYER, DEALER} side_t;

  state_t     state_q, state_d;
  side_t      last_q, last_d;   // side granted most recently
  side_t      sel_q, sel_d;     // side being served in WRITE
  logic [3:0] code_q, code_d;   // card code captured at grant
  logic [7:0] addr_q, addr_d;   // clear sweep address {yt, xt}

  logic       p_ack_q, p_ack_d;
  logic       d_ack_q, d_ack_d;
  logic       err_q, err_d;
  logic [3:0] p_count_q, p_count_d;
  logic [3:0] d_count_q, d_count_d;
  logic       busy_q, busy_d;
  logic [4:0] xt_q, xt_d;
  logic [2:0] yt_q, yt_d;
  logic [5:0] ch_q, ch_d;
  logic       we_q, we_d;

  logic       p_pend, d_pend;
  logic [3:0] cnt;
  logic [4:0] slot_x;
  logic [2:0] row;

  // Next-state, grant arbitration and registered-output values.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned; a missing default would infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    code_d    = code_q;
    addr_d    = addr_q;
    p_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    p_count_d = p_count_q;
    d_count_d = d_count_q;
    xt_d      = '0;
    yt_d      = '0;
    ch_d      = '0;
    we_d      = 1'b0;
    cnt       = '0;
    slot_x    = '0;
    row       = '0;
    // The requester still holds req during the cycle its ack is visible;
    // masking with the ack keeps that request from being granted twice.
    p_pend    = p_req & ~p_ack_q;
    d_pend    = d_req & ~d_ack_q;

    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          addr_d  = '0;
          we_d    = 1'b1;          // first sweep write: tile {0,0} = empty
        end else if (p_pend || d_pend) begin
          state_d = WRITE;
          if (p_pend && (!d_pend || last_q == DEALER)) begin
            sel_d  = PLAYER;
            code_d = p_code;
          end else begin
            sel_d  = DEALER;
            code_d = d_code;
          end
        end
      end

      WRITE: begin
        state_d = IDLE;
        last_d  = sel_q;
        if (sel_q == PLAYER) begin
          cnt     = p_count_q;
          row     = 3'(P_ROW);
          p_ack_d = 1'b1;
        end else begin
          cnt     = d_count_q;
          row     = 3'(D_ROW);
          d_ack_d = 1'b1;
        end
        slot_x = 5'(X_START) + 5'(X_STEP) * {1'b0, cnt};
        if (code_q == 4'd0 || cnt == 4'(MAX_CARDS)) begin
          err_d = 1'b1;            // empty code or full hand: ack, no write
        end else begin
          we_d = 1'b1;
          xt_d = slot_x;
          yt_d = row;
          ch_d = {2'b00, code_q};
          if (sel_q == PLAYER) p_count_d = p_count_q + 4'd1;
          else                 d_count_d = d_count_q + 4'd1;
        end
      end

      CLEAR: begin
        if (addr_q == 8'hFF) begin
          state_d   = IDLE;
          p_count_d = '0;
          d_count_d = '0;
        end else begin
          addr_d       = addr_q + 8'd1;
          we_d         = 1'b1;
          {yt_d, xt_d} = addr_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset returns to IDLE with all outputs low.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= DEALER;
      sel_q     <= PLAYER;
      code_q    <= '0;
      addr_q    <= '0;
      p_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      p_count_q <= '0;
      d_count_q <= '0;
      busy_q    <= 1'b0;
      xt_q      <= '0;
      yt_q      <= '0;
      ch_q      <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      code_q    <= code_d;
      addr_q    <= addr_d;
      p_ack_q   <= p_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
      p_count_q <= p_count_d;
      d_count_q <= d_count_d;
      busy_q    <= busy_d;
      xt_q      <= xt_d;
      yt_q      <= yt_d;
      ch_q      <= ch_d;
      we_q      <= we_d;
    end
  end

  assign p_ack   = p_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;
  assign p_count = p_count_q;
  assign d_count = d_count_q;
  assign busy    = busy_q;
  assign xt      = xt_q;
  assign yt      = yt_q;
  assign ch_out  = ch_q;
  assign we_ch   = we_q;

endmodule
